// File: rtl/regfile_sb_if.sv
// Bus bundle for the regfile_sb register file.
// Handshake: there is no valid/ready pair. RegWEn and issue_en are
// single-cycle strobes sampled on the rising clock edge. The read path
// (rd_addr -> rd_data/rd_busy) is purely combinational and always
// valid. pend_cnt and any_pend are registered outputs.
//  master : decode/writeback side, drives strobes, addresses and data
//  slave  : register file, drives read data, busy flags and pending count
interface regfile_sb_if #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_RD         = 2
);
  logic                             RegWEn;
  logic [REG_ADDR_WIDTH-1:0]        addrD;
  logic [REG_WIDTH-1:0]             dataD;
  logic                             issue_en;
  logic [REG_ADDR_WIDTH-1:0]        issue_addr;
  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*REG_WIDTH-1:0]      rd_data;
  logic [NUM_RD-1:0]                rd_busy;
  logic [REG_ADDR_WIDTH:0]          pend_cnt;
  logic                             any_pend;

  modport master (
    output RegWEn, addrD, dataD, issue_en, issue_addr, rd_addr,
    input  rd_data, rd_busy, pend_cnt, any_pend
  );

  modport slave (
    input  RegWEn, addrD, dataD, issue_en, issue_addr, rd_addr,
    output rd_data, rd_busy, pend_cnt, any_pend
  );
endinterface

// File: rtl/regfile_sb.sv
// N-read / 1-write register file with r0 hardwired to zero, optional
// same-cycle write-to-read bypass and a per-register pending scoreboard.
// Ports:
//  clk    : clock, all state updates on the rising edge
//  reset  : synchronous, active-high; clears registers, pending bits
//           and count, and forces read outputs to zero while asserted
//  bus    : regfile_sb_if slave (writeback, issue, read ports, count)
module regfile_sb #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_DEPTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_RD         = 2,
  parameter int BYPASS         = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  localparam int W  = REG_WIDTH;
  localparam int AW = REG_ADDR_WIDTH;

  logic [W-1:0]         r_regs [REG_DEPTH];
  logic [REG_DEPTH-1:0] r_pend;
  logic [AW:0]          r_pend_cnt;

  logic                 w_wr;
  logic                 w_set;
  logic                 w_inc;
  logic                 w_dec;
  logic [REG_DEPTH-1:0] w_pend_nxt;
  logic [AW:0]          w_cnt_nxt;
  logic [NUM_RD*W-1:0]  w_rd_data;
  logic [NUM_RD-1:0]    w_rd_busy;

  // Address 0 is inert for both data and scoreboard.
  assign w_wr  = bus.RegWEn   && (bus.addrD      != '0);
  assign w_set = bus.issue_en && (bus.issue_addr != '0);

  // Clear first, set second: a new producer issued in the same cycle as
  // the old one's writeback keeps the register pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr)  w_pend_nxt[bus.addrD]      = 1'b0;
    if (w_set) w_pend_nxt[bus.issue_addr] = 1'b1;
  end

  // Count tracks only real bit transitions so it always equals popcount.
  assign w_inc = w_set && !r_pend[bus.issue_addr];
  assign w_dec = w_wr && r_pend[bus.addrD] &&
                 !(w_set && (bus.issue_addr == bus.addrD));
  assign w_cnt_nxt = r_pend_cnt + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_DEPTH; i++) r_regs[i] <= '0;
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      if (w_wr) r_regs[bus.addrD] <= bus.dataD;
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_cnt_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_fwd;
    assign w_ra  = bus.rd_addr[k*AW +: AW];
    // Forwarded read sees the producer completing now, so it is not busy.
    assign w_fwd = (BYPASS != 0) && bus.RegWEn && (bus.addrD == w_ra);
    assign w_rd_data[k*W +: W] = (reset || (w_ra == '0)) ? '0 :
                                 w_fwd ? bus.dataD : r_regs[w_ra];
    assign w_rd_busy[k] = (reset || (w_ra == '0) || w_fwd) ? 1'b0 :
                          r_pend[w_ra];
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.rd_busy  = w_rd_busy;
  assign bus.pend_cnt = r_pend_cnt;
  assign bus.any_pend = (r_pend_cnt != '0);
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          t_rst;
  logic          t_we;
  logic [AW-1:0] t_ad;
  logic [W-1:0]  t_dd;
  logic          t_iss;
  logic [AW-1:0] t_ia;
  logic [AW-1:0] t_ra0;
  logic [AW-1:0] t_ra1;

  regfile_sb_if #(.REG_WIDTH(W), .REG_ADDR_WIDTH(AW), .NUM_RD(NR)) bus_b ();
  regfile_sb_if #(.REG_WIDTH(W), .REG_ADDR_WIDTH(AW), .NUM_RD(NR)) bus_n ();

  assign bus_b.RegWEn = t_we;  assign bus_n.RegWEn = t_we;
  assign bus_b.addrD  = t_ad;  assign bus_n.addrD  = t_ad;
  assign bus_b.dataD  = t_dd;  assign bus_n.dataD  = t_dd;
  assign bus_b.issue_en   = t_iss; assign bus_n.issue_en   = t_iss;
  assign bus_b.issue_addr = t_ia;  assign bus_n.issue_addr = t_ia;
  assign bus_b.rd_addr = {t_ra1, t_ra0};
  assign bus_n.rd_addr = {t_ra1, t_ra0};

  regfile_sb #(.REG_WIDTH(W), .REG_DEPTH(32), .REG_ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(1))
    u_dut_b (.clk(clk), .reset(t_rst), .bus(bus_b));
  regfile_sb #(.REG_WIDTH(W), .REG_DEPTH(32), .REG_ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(0))
    u_dut_n (.clk(clk), .reset(t_rst), .bus(bus_n));

  logic [W-1:0] b_d0, b_d1, n_d0, n_d1;
  logic         b_b0, b_b1, n_b0, n_b1;
  assign b_d0 = bus_b.rd_data[0 +: W];
  assign b_d1 = bus_b.rd_data[W +: W];
  assign n_d0 = bus_n.rd_data[0 +: W];
  assign n_d1 = bus_n.rd_data[W +: W];
  assign b_b0 = bus_b.rd_busy[0];
  assign b_b1 = bus_b.rd_busy[1];
  assign n_b0 = bus_n.rd_busy[0];
  assign n_b1 = bus_n.rd_busy[1];

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic set_in(input logic rst, input logic we, input logic [AW-1:0] ad,
                        input logic [W-1:0] dd, input logic iss, input logic [AW-1:0] ia,
                        input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    @(negedge clk);
    t_rst = rst; t_we = we; t_ad = ad; t_dd = dd;
    t_iss = iss; t_ia = ia; t_ra0 = ra0; t_ra1 = ra1;
    #2;
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_regs [32];
  logic         m_pend [32];
  int           m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 1'b0; end
    m_cnt = 0;
  endtask

  // State after the coming rising edge, given the inputs now applied.
  task automatic model_step();
    if (t_rst) begin
      model_reset();
    end else begin
      if (t_we && t_ad != 0) m_regs[t_ad] = t_dd;
      if (t_we && t_ad != 0 && !(t_iss && t_ia == t_ad)) begin
        if (m_pend[t_ad]) m_cnt--;
        m_pend[t_ad] = 1'b0;
      end
      if (t_iss && t_ia != 0) begin
        if (!m_pend[t_ia]) m_cnt++;
        m_pend[t_ia] = 1'b1;
      end
    end
  endtask

  function automatic logic [W-1:0] exp_d(input logic [AW-1:0] a, input bit byp);
    if (t_rst || a == 0) return '0;
    if (byp && t_we && t_ad == a) return t_dd;
    return m_regs[a];
  endfunction

  function automatic logic exp_b(input logic [AW-1:0] a, input bit byp);
    if (t_rst || a == 0) return 1'b0;
    if (byp && t_we && t_ad == a) return 1'b0;
    return m_pend[a];
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] ad;
    logic [W-1:0]  dd;
    logic          iss;
    logic [AW-1:0] ia;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [W-1:0]  d0;
    logic [W-1:0]  d1;
    logic [W-1:0]  nd0;
    logic          b0;
    logic          b1;
    logic [AW:0]   cnt;
  } vec_t;

  vec_t vecs [18];

  initial begin
    t_rst = 1'b1; t_we = 0; t_ad = 0; t_dd = 0; t_iss = 0; t_ia = 0; t_ra0 = 0; t_ra1 = 0;

    //            we ad  dd            iss ia ra0 ra1  d0            d1            nd0           b0 b1 cnt
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0, 0, 0};
    vecs[1]  = '{0, 0, 32'h0,        0, 0, 5, 0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 0, 0};
    vecs[2]  = '{0, 0, 32'h0,        1, 7, 7, 5, 32'h0,        32'hDEADBEEF, 32'h0,        0, 0, 0};
    vecs[3]  = '{0, 0, 32'h0,        0, 0, 7, 7, 32'h0,        32'h0,        32'h0,        1, 1, 1};
    vecs[4]  = '{1, 7, 32'h12,       0, 0, 7, 7, 32'h12,       32'h12,       32'h0,        0, 0, 1};
    vecs[5]  = '{0, 0, 32'h0,        0, 0, 7, 0, 32'h12,       32'h0,        32'h12,       0, 0, 0};
    vecs[6]  = '{0, 0, 32'h0,        1, 9, 9, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0};
    vecs[7]  = '{0, 0, 32'h0,        1, 4, 9, 0, 32'h0,        32'h0,        32'h0,        1, 0, 1};
    vecs[8]  = '{1, 9, 32'h99,       1, 9, 9, 4, 32'h99,       32'h0,        32'h0,        0, 1, 2};
    vecs[9]  = '{0, 0, 32'h0,        0, 0, 9, 4, 32'h99,       32'h0,        32'h99,       1, 1, 2};
    vecs[10] = '{1, 4, 32'h44,       1, 3, 3, 4, 32'h0,        32'h44,       32'h0,        0, 0, 2};
    vecs[11] = '{0, 0, 32'h0,        0, 0, 3, 4, 32'h0,        32'h44,       32'h0,        1, 0, 2};
    vecs[12] = '{1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 2};
    vecs[13] = '{0, 0, 32'h0,        0, 0, 0, 9, 32'h0,        32'h99,       32'h0,        0, 1, 2};
    vecs[14] = '{1, 5, 32'h55,       0, 0, 5, 3, 32'h55,       32'h0,        32'hDEADBEEF, 0, 1, 2};
    vecs[15] = '{0, 0, 32'h0,        0, 0, 5, 3, 32'h55,       32'h0,        32'h55,       0, 1, 2};
    vecs[16] = '{0, 0, 32'h0,        1, 9, 9, 0, 32'h99,       32'h0,        32'h99,       1, 0, 2};
    vecs[17] = '{0, 0, 32'h0,        0, 0, 9, 0, 32'h99,       32'h0,        32'h99,       1, 0, 2};

    // Reset, then sweep every address on both ports.
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 32; a++) begin
      set_in(0, 0, 0, 0, 0, 0, AW'(a), AW'(31 - a));
      chk("reset_d0", b_d0, 0);
      chk("reset_d1", b_d1, 0);
      chk("reset_b0", b_b0, 0);
      chk("reset_b1", b_b1, 0);
    end
    chk("reset_cnt", bus_b.pend_cnt, 0);
    chk("reset_any", bus_b.any_pend, 0);

    for (int i = 0; i < 18; i++) begin
      set_in(0, vecs[i].we, vecs[i].ad, vecs[i].dd, vecs[i].iss, vecs[i].ia,
             vecs[i].ra0, vecs[i].ra1);
      chk($sformatf("v%0d_d0", i), b_d0, vecs[i].d0);
      chk($sformatf("v%0d_d1", i), b_d1, vecs[i].d1);
      chk($sformatf("v%0d_b0", i), b_b0, vecs[i].b0);
      chk($sformatf("v%0d_b1", i), b_b1, vecs[i].b1);
      chk($sformatf("v%0d_nobyp_d0", i), n_d0, vecs[i].nd0);
      chk($sformatf("v%0d_cnt", i), bus_b.pend_cnt, vecs[i].cnt);
      chk($sformatf("v%0d_any", i), bus_b.any_pend, vecs[i].cnt != 0);
    end

    // Fill the scoreboard (x9 and x3 already pending), then reset mid-flight.
    for (int a = 1; a < 32; a++) set_in(0, 0, 0, 0, 1, AW'(a), 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 1, 31);
    chk("full_cnt", bus_b.pend_cnt, 31);
    chk("full_any", bus_b.any_pend, 1);
    chk("full_b0", b_b0, 1);
    chk("full_b1", b_b1, 1);
    set_in(1, 1, 3, 32'h33, 1, 2, 9, 5);
    chk("in_reset_d0", b_d0, 0);
    chk("in_reset_d1", b_d1, 0);
    chk("in_reset_b0", b_b0, 0);
    chk("in_reset_b1", b_b1, 0);
    chk("in_reset_nobyp_d0", n_d0, 0);
    for (int a = 0; a < 32; a++) begin
      set_in(0, 0, 0, 0, 0, 0, AW'(a), AW'(a ^ 3));
      chk("post_reset_d0", b_d0, 0);
      chk("post_reset_b0", b_b0, 0);
      chk("post_reset_d1", b_d1, 0);
      chk("post_reset_b1", b_b1, 0);
    end
    chk("post_reset_cnt", bus_b.pend_cnt, 0);

    // Random mix against the reference model, narrow address range for collisions.
    model_reset();
    for (int c = 0; c < 300; c++) begin
      set_in($urandom_range(0, 39) == 0, $urandom_range(0, 1), AW'($urandom_range(0, 7)),
             $urandom, $urandom_range(0, 1), AW'($urandom_range(0, 7)),
             AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      chk("rnd_b_d0", b_d0, exp_d(t_ra0, 1));
      chk("rnd_b_d1", b_d1, exp_d(t_ra1, 1));
      chk("rnd_b_b0", b_b0, exp_b(t_ra0, 1));
      chk("rnd_b_b1", b_b1, exp_b(t_ra1, 1));
      chk("rnd_n_d0", n_d0, exp_d(t_ra0, 0));
      chk("rnd_n_d1", n_d1, exp_d(t_ra1, 0));
      chk("rnd_n_b0", n_b0, exp_b(t_ra0, 0));
      chk("rnd_n_b1", n_b1, exp_b(t_ra1, 0));
      chk("rnd_cnt", bus_b.pend_cnt, 64'(m_cnt));
      chk("rnd_any", bus_b.any_pend, m_cnt != 0);
      chk("rnd_n_cnt", bus_n.pend_cnt, 64'(m_cnt));
      model_step();
    end

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
